// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter feeding the register-file write port.
// ALU results always win the write slot; load returns bypass when the path
// is clear and otherwise queue in a DEPTH-entry FIFO. Queued loads whose
// destination is overwritten by a later ALU write are squashed (marked dead)
// and discarded silently when they reach the head.
//
// Optional feature macro: WB_R0_ZERO_EN (register 0 hardwired to zero).
//
// Ports:
//   clk, reset(async, active-low), enable (global run)
//   alu_valid/alu_rd/alu_data       ALU result, no backpressure
//   mem_valid/mem_ready/mem_rd/mem_data  load return handshake
//   RegW/RD/WriteData               registered register-file write
//   pending                         registered live-destination scoreboard
//   fifo_count                      registered FIFO occupancy
module wb_arbiter #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     alu_valid,
  input  logic [REG_AW-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [REG_AW-1:0]        mem_rd,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     RegW,
  output logic [REG_AW-1:0]        RD,
  output logic [DATA_W-1:0]        WriteData,
  output logic [(1<<REG_AW)-1:0]   pending,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREG  = 1 << REG_AW;

  // FIFO storage
  logic [DEPTH-1:0]  live_q;
  logic [REG_AW-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;

  // Next-state
  logic [DEPTH-1:0]  live_n;
  logic [REG_AW-1:0] rd_n   [DEPTH];
  logic [DATA_W-1:0] data_n [DEPTH];
  logic [PTR_W-1:0]  head_n, tail_n;
  logic [CNT_W-1:0]  count_n;
  logic [NREG-1:0]   pending_n;
  logic              regw_n;
  logic [REG_AW-1:0] rd_out_n;
  logic [DATA_W-1:0] wd_n;

  logic accept, fifo_empty, pop, bypass, enq, squash;
  logic alu_wr, mem_keep;

  // r0 filtering: an ALU write to r0 neither writes nor squashes, and a
  // load to r0 is accepted but goes nowhere.
`ifdef WB_R0_ZERO_EN
  assign alu_wr   = alu_valid & (alu_rd != '0);
  assign mem_keep = (mem_rd != '0);
`else
  assign alu_wr   = alu_valid;
  assign mem_keep = 1'b1;
`endif

  // Ready uses the registered count only, so a full FIFO never accepts
  // on the cycle it drains.
  assign mem_ready  = reset & enable & (fifo_count < CNT_W'(DEPTH));
  assign accept     = mem_valid & mem_ready;
  assign fifo_empty = (fifo_count == '0);
  assign pop        = enable & ~alu_valid & ~fifo_empty;
  assign bypass     = enable & ~alu_valid & fifo_empty & accept;
  assign enq        = accept & ~bypass & mem_keep;
  assign squash     = enable & alu_wr;

  // Next-state for FIFO, scoreboard and write port
  always_comb begin
    live_n   = live_q;
    rd_n     = rd_q;
    data_n   = data_q;
    head_n   = head_q;
    tail_n   = tail_q;
    regw_n   = 1'b0;
    rd_out_n = RD;
    wd_n     = WriteData;

    for (int i = 0; i < DEPTH; i++) begin
      if (squash && (rd_q[i] == alu_rd)) live_n[i] = 1'b0;
    end

    if (pop) begin
      live_n[head_q] = 1'b0;
      head_n         = head_q + PTR_W'(1);
    end

    // A load arriving with a same-rd ALU write is older, so it lands dead.
    if (enq) begin
      live_n[tail_q] = ~(squash && (mem_rd == alu_rd));
      rd_n[tail_q]   = mem_rd;
      data_n[tail_q] = mem_data;
      tail_n         = tail_q + PTR_W'(1);
    end

    count_n = fifo_count + CNT_W'(enq) - CNT_W'(pop);

    if (enable) begin
      if (alu_valid) begin
        regw_n = alu_wr;
        if (alu_wr) begin
          rd_out_n = alu_rd;
          wd_n     = alu_data;
        end
      end else if (pop) begin
        regw_n = live_q[head_q];
        if (live_q[head_q]) begin
          rd_out_n = rd_q[head_q];
          wd_n     = data_q[head_q];
        end
      end else if (bypass) begin
        regw_n = mem_keep;
        if (mem_keep) begin
          rd_out_n = mem_rd;
          wd_n     = mem_data;
        end
      end
    end

    pending_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_n[i]) pending_n[rd_n[i]] = 1'b1;
    end
`ifdef WB_R0_ZERO_EN
    pending_n[0] = 1'b0;
`endif
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fifo_count <= '0;
      pending    <= '0;
      RegW       <= 1'b0;
      RD         <= '0;
      WriteData  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (enable) begin
      live_q     <= live_n;
      head_q     <= head_n;
      tail_q     <= tail_n;
      fifo_count <= count_n;
      pending    <= pending_n;
      RegW       <= regw_n;
      RD         <= rd_out_n;
      WriteData  <= wd_n;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= rd_n[i];
        data_q[i] <= data_n[i];
      end
    end else begin
      RegW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default parameters).
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [15:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_rd;
  logic [15:0] mem_data;
  logic        RegW;
  logic [3:0]  RD;
  logic [15:0] WriteData;
  logic [15:0] pending;
  logic [2:0]  fifo_count;

  int n_chk  = 0;
  int n_fail = 0;

  wb_arbiter dut (
    .clk(clk), .reset(reset), .enable(enable),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_data(mem_data),
    .RegW(RegW), .RD(RD), .WriteData(WriteData),
    .pending(pending), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                       input logic mv, input logic [3:0] mr, input logic [15:0] md);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
  endtask

  task automatic wr(input string tag, input logic w, input logic [3:0] r, input logic [15:0] d);
    chk({tag, ".RegW"}, 32'(RegW), 32'(w));
    chk({tag, ".RD"}, 32'(RD), 32'(r));
    chk({tag, ".WD"}, 32'(WriteData), 32'(d));
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    // Reset held
    chk("rst.RegW", 32'(RegW), 32'd0);
    chk("rst.mem_ready", 32'(mem_ready), 32'd0);
    chk("rst.count", 32'(fifo_count), 32'd0);
    reset = 1'b1;
    tick();
    wr("idle", 0, 4'd0, 16'h0000);
    chk("idle.mem_ready", 32'(mem_ready), 32'd1);
    chk("idle.pending", 32'(pending), 32'd0);
    chk("idle.count", 32'(fifo_count), 32'd0);

    // Bypass
    drive(0, 0, 0, 1, 4'd3, 16'h1234);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    wr("byp", 1, 4'd3, 16'h1234);
    chk("byp.count", 32'(fifo_count), 32'd0);

    // Collision: ALU wins, load queued
    drive(1, 4'd5, 16'hAAAA, 1, 4'd6, 16'hBBBB);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    wr("col1", 1, 4'd5, 16'hAAAA);
    chk("col1.pending", 32'(pending), 32'h0040);
    chk("col1.count", 32'(fifo_count), 32'd1);
    tick();
    wr("col2", 1, 4'd6, 16'hBBBB);
    chk("col2.pending", 32'(pending), 32'd0);
    chk("col2.count", 32'(fifo_count), 32'd0);
    tick();
    wr("hold", 0, 4'd6, 16'hBBBB);

    // Fill under ALU traffic
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'd1, 16'(i), 1, 4'(8 + i), 16'hC000 + 16'(i));
      tick();
      chk("fill.count", 32'(fifo_count), 32'(i + 1));
    end
    chk("full.mem_ready", 32'(mem_ready), 32'd0);
    chk("full.pending", 32'(pending), 32'h0F00);
    drive(1, 4'd1, 16'h0055, 1, 4'd12, 16'hDEAD);
    tick();
    chk("full.noacc", 32'(fifo_count), 32'd4);
    wr("full.alu", 1, 4'd1, 16'h0055);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      wr("drain", 1, 4'(8 + i), 16'hC000 + 16'(i));
      chk("drain.count", 32'(fifo_count), 32'(3 - i));
    end
    tick();
    wr("drained", 0, 4'd11, 16'hC003);

    // Squash of an already queued load
    drive(1, 4'd7, 16'h7777, 1, 4'd2, 16'h1111);
    tick();
    wr("sq1", 1, 4'd7, 16'h7777);
    chk("sq1.pending", 32'(pending), 32'h0004);
    drive(1, 4'd2, 16'h2222, 0, 0, 0);
    tick();
    wr("sq2", 1, 4'd2, 16'h2222);
    chk("sq2.pending", 32'(pending), 32'd0);
    chk("sq2.count", 32'(fifo_count), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    wr("sq3.dead", 0, 4'd2, 16'h2222);
    chk("sq3.count", 32'(fifo_count), 32'd0);

    // Same-cycle squash: load and ALU both target r9
    drive(1, 4'd9, 16'h9999, 1, 4'd9, 16'h0909);
    tick();
    wr("ssq1", 1, 4'd9, 16'h9999);
    chk("ssq1.pending", 32'(pending), 32'd0);
    chk("ssq1.count", 32'(fifo_count), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    wr("ssq2", 0, 4'd9, 16'h9999);
    chk("ssq2.count", 32'(fifo_count), 32'd0);

    // Three queued, then freeze, then async reset
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'd1, 16'h0100 + 16'(i), 1, 4'(4 + i), 16'hE000 + 16'(i));
      tick();
    end
    chk("q3.count", 32'(fifo_count), 32'd3);
    chk("q3.pending", 32'(pending), 32'h0070);
    enable = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("frz.mem_ready", 32'(mem_ready), 32'd0);
    tick();
    wr("frz1", 0, 4'd1, 16'h0102);
    chk("frz1.count", 32'(fifo_count), 32'd3);
    drive(1, 4'd4, 16'h4444, 1, 4'd13, 16'hF00D);
    tick();
    wr("frz2", 0, 4'd1, 16'h0102);
    chk("frz2.count", 32'(fifo_count), 32'd3);
    chk("frz2.pending", 32'(pending), 32'h0070);
    drive(0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst.count", 32'(fifo_count), 32'd0);
    chk("arst.pending", 32'(pending), 32'd0);
    wr("arst", 0, 4'd0, 16'h0000);
    tick();
    reset = 1'b1;
    enable = 1'b1;
    tick();
    wr("post", 0, 4'd0, 16'h0000);
    chk("post.count", 32'(fifo_count), 32'd0);
    chk("post.mem_ready", 32'(mem_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
